// File: rtl/tx_reset_seq_fsm.sv
// ---------------------------------------------------------------------------
// tx_reset_seq_fsm
//
// GTX transmit reset sequencer placed directly upstream of the TX phase-sync
// FSM. After reset it waits for LOCK_WAIT consecutive cycles of PLL lock,
// pulses GTXTXRESET for RST_HOLD cycles and waits for TXRESETDONE. It then
// releases SYNC_RST and waits for SYNC_DONE, after which TX_READY is raised.
// Loss of PLL lock in any post-lock state restarts the sequence from the lock
// wait.
//
// Build option:
//   TXRST_WATCHDOG_EN  When defined, Sync is bounded to SYNC_TIMEOUT cycles.
//                      A timeout retries from GTX_Reset up to MAX_RETRY times,
//                      then parks in Fail with TX_FAIL set until RST.
//                      When undefined, Sync waits indefinitely, TX_FAIL and
//                      RETRY_CNT stay 0.
//
// Parameters:
//   LOCK_WAIT     consecutive PLLLKDET=1 cycles required before GTX reset (>=2)
//   RST_HOLD      cycles GTXTXRESET is held in GTX_Reset (>=2)
//   SYNC_TIMEOUT  cycles allowed in Sync for SYNC_DONE (watchdog build)
//   MAX_RETRY     sync retries before Fail, 0..15 (watchdog build)
//
// Ports:
//   CLK          in   transmit user clock
//   RST          in   asynchronous, active-high reset
//   PLLLKDET     in   GTX TX PLL lock detect (synchronised upstream)
//   TXRESETDONE  in   GTX TX reset-done (synchronised upstream)
//   SYNC_DONE    in   phase-sync FSM done
//   GTXTXRESET   out  GTX TX reset request
//   SYNC_RST     out  reset to the phase-sync FSM, active-high
//   TX_READY     out  TX path aligned and usable
//   TX_FAIL      out  retries exhausted, sticky until RST
//   RETRY_CNT    out  [3:0] sync retries used since RST
//
// All outputs are registered and decoded from the next state, so they change
// on the same edge that enters a state.
// ---------------------------------------------------------------------------
module tx_reset_seq_fsm #(
  parameter int unsigned LOCK_WAIT    = 1024,
  parameter int unsigned RST_HOLD     = 16,
  parameter int unsigned SYNC_TIMEOUT = 16384,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PLLLKDET,
  input  logic       TXRESETDONE,
  input  logic       SYNC_DONE,
  output logic       GTXTXRESET,
  output logic       SYNC_RST,
  output logic       TX_READY,
  output logic       TX_FAIL,
  output logic [3:0] RETRY_CNT
);

  // Counter widths and terminal values.
  localparam int unsigned LcntW = $clog2(LOCK_WAIT);
  localparam int unsigned HcntW = $clog2(RST_HOLD);
  localparam int unsigned ScntW = $clog2(SYNC_TIMEOUT);

  localparam logic [LcntW-1:0] LcntMax  = LcntW'(LOCK_WAIT - 1);
  localparam logic [HcntW-1:0] HcntMax  = HcntW'(RST_HOLD - 1);
  localparam logic [ScntW-1:0] ScntMax  = ScntW'(SYNC_TIMEOUT - 1);
  localparam logic [3:0]       MaxRetry = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    StIdle,
    StWaitLock,
    StGtxReset,
    StWaitDone,
    StSync,
    StReady,
    StFail
  } state_e;

  state_e           state_q, state_d;
  logic [LcntW-1:0] lcnt_q, lcnt_d;
  logic [HcntW-1:0] hcnt_q, hcnt_d;
  logic [ScntW-1:0] scnt_q, scnt_d;
  logic [3:0]       retry_q, retry_d;

  logic gtx_q, gtx_d;
  logic srst_q, srst_d;
  logic ready_q, ready_d;
  logic fail_q, fail_d;

  // Sync watchdog expiry. Tied off in the default build, which leaves the
  // retry/Fail path unreachable and RETRY_CNT constant at zero.
  logic sync_timeout;

`ifdef TXRST_WATCHDOG_EN
  assign sync_timeout = (scnt_q == ScntMax);
`else
  assign sync_timeout = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state and counter logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    hcnt_d  = hcnt_q;
    scnt_d  = scnt_q;
    retry_d = retry_q;

    case (state_q)
      StIdle: begin
        state_d = StWaitLock;
      end

      StWaitLock: begin
        // Lock must be seen on LOCK_WAIT consecutive cycles; any drop restarts.
        if (!PLLLKDET) begin
          lcnt_d = '0;
        end else if (lcnt_q == LcntMax) begin
          state_d = StGtxReset;
        end else begin
          lcnt_d = lcnt_q + LcntW'(1);
        end
      end

      StGtxReset: begin
        if (!PLLLKDET) begin
          state_d = StWaitLock;
        end else if (hcnt_q == HcntMax) begin
          state_d = StWaitDone;
        end else begin
          hcnt_d = hcnt_q + HcntW'(1);
        end
      end

      StWaitDone: begin
        if (!PLLLKDET) begin
          state_d = StWaitLock;
        end else if (TXRESETDONE) begin
          state_d = StSync;
        end
      end

      StSync: begin
        // Priority: lock loss, then SYNC_DONE (wins on the timeout cycle),
        // then watchdog expiry.
        if (!PLLLKDET) begin
          state_d = StWaitLock;
        end else if (SYNC_DONE) begin
          state_d = StReady;
        end else if (sync_timeout) begin
          if (retry_q < MaxRetry) begin
            retry_d = retry_q + 4'd1;
            state_d = StGtxReset;
          end else begin
            state_d = StFail;
          end
        end else if (scnt_q != ScntMax) begin
          // Saturate rather than wrap when no watchdog is present.
          scnt_d = scnt_q + ScntW'(1);
        end
      end

      StReady: begin
        if (!PLLLKDET) begin
          state_d = StWaitLock;
        end
      end

      StFail: begin
        state_d = StFail;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Every state change starts all counters from zero.
    if (state_d != state_q) begin
      lcnt_d = '0;
      hcnt_d = '0;
      scnt_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode from the next state
  // -------------------------------------------------------------------------
  always_comb begin
    gtx_d   = 1'b1;
    srst_d  = 1'b1;
    ready_d = 1'b0;
    fail_d  = 1'b0;

    case (state_d)
      StWaitDone: begin
        gtx_d = 1'b0;
      end
      StSync: begin
        gtx_d  = 1'b0;
        srst_d = 1'b0;
      end
      StReady: begin
        gtx_d   = 1'b0;
        srst_d  = 1'b0;
        ready_d = 1'b1;
      end
      StFail: begin
        fail_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, counters and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      lcnt_q  <= '0;
      hcnt_q  <= '0;
      scnt_q  <= '0;
      retry_q <= '0;
      gtx_q   <= 1'b1;
      srst_q  <= 1'b1;
      ready_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      hcnt_q  <= hcnt_d;
      scnt_q  <= scnt_d;
      retry_q <= retry_d;
      gtx_q   <= gtx_d;
      srst_q  <= srst_d;
      ready_q <= ready_d;
      fail_q  <= fail_d;
    end
  end

  assign GTXTXRESET = gtx_q;
  assign SYNC_RST   = srst_q;
  assign TX_READY   = ready_q;
  assign TX_FAIL    = fail_q;
  assign RETRY_CNT  = retry_q;

endmodule

// File: tb/tb_tx_reset_seq_fsm.sv
// ---------------------------------------------------------------------------
// tb_tx_reset_seq_fsm
//
// Self-checking bench for tx_reset_seq_fsm. A phase-level reference model
// (phase + cycles-in-phase + retries) predicts every output each cycle.
// Directed sequences check absolute edge timings against hand-derived
// constants; a randomized section exercises lock loss, resets and sync
// timing. Define TXRST_WATCHDOG_EN to also cover the watchdog build.
// ---------------------------------------------------------------------------
module tb_tx_reset_seq_fsm;

  localparam int LW = 8;
  localparam int RH = 4;
  localparam int ST = 64;
  localparam int MR = 2;

`ifdef TXRST_WATCHDOG_EN
  localparam bit WdEn = 1'b1;
`else
  localparam bit WdEn = 1'b0;
`endif

  // Model phases.
  localparam int PH_IDLE  = 0;
  localparam int PH_WLOCK = 1;
  localparam int PH_GRST  = 2;
  localparam int PH_WDONE = 3;
  localparam int PH_SYNC  = 4;
  localparam int PH_READY = 5;
  localparam int PH_FAIL  = 6;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PLLLKDET = 1'b0;
  logic       TXRESETDONE = 1'b0;
  logic       SYNC_DONE = 1'b0;
  logic       GTXTXRESET;
  logic       SYNC_RST;
  logic       TX_READY;
  logic       TX_FAIL;
  logic [3:0] RETRY_CNT;

  int n_cmp = 0;
  int n_err = 0;

  int m_ph    = PH_IDLE;
  int m_cnt   = 0;
  int m_retry = 0;

  tx_reset_seq_fsm #(
    .LOCK_WAIT    (LW),
    .RST_HOLD     (RH),
    .SYNC_TIMEOUT (ST),
    .MAX_RETRY    (MR)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .PLLLKDET    (PLLLKDET),
    .TXRESETDONE (TXRESETDONE),
    .SYNC_DONE   (SYNC_DONE),
    .GTXTXRESET  (GTXTXRESET),
    .SYNC_RST    (SYNC_RST),
    .TX_READY    (TX_READY),
    .TX_FAIL     (TX_FAIL),
    .RETRY_CNT   (RETRY_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_ph    = PH_IDLE;
    m_cnt   = 0;
    m_retry = 0;
  endtask

  task automatic model_step(input logic pll, input logic trd, input logic sd);
    int nph;
    nph = m_ph;
    case (m_ph)
      PH_IDLE:  nph = PH_WLOCK;
      PH_WLOCK: begin
        if (!pll) m_cnt = 0;
        else if (m_cnt == LW - 1) nph = PH_GRST;
        else m_cnt++;
      end
      PH_GRST: begin
        if (!pll) nph = PH_WLOCK;
        else if (m_cnt == RH - 1) nph = PH_WDONE;
        else m_cnt++;
      end
      PH_WDONE: begin
        if (!pll) nph = PH_WLOCK;
        else if (trd) nph = PH_SYNC;
      end
      PH_SYNC: begin
        if (!pll) nph = PH_WLOCK;
        else if (sd) nph = PH_READY;
        else if (WdEn && m_cnt == ST - 1) begin
          if (m_retry < MR) begin
            m_retry++;
            nph = PH_GRST;
          end else begin
            nph = PH_FAIL;
          end
        end else m_cnt++;
      end
      PH_READY: if (!pll) nph = PH_WLOCK;
      default: ;
    endcase
    if (nph != m_ph) begin
      m_ph  = nph;
      m_cnt = 0;
    end
  endtask

  task automatic check_outputs();
    logic e_gtx, e_srst;
    e_gtx  = (m_ph == PH_IDLE) || (m_ph == PH_WLOCK) || (m_ph == PH_GRST) || (m_ph == PH_FAIL);
    e_srst = (m_ph != PH_SYNC) && (m_ph != PH_READY);
    check("gtx",   32'(GTXTXRESET), 32'(e_gtx));
    check("srst",  32'(SYNC_RST),   32'(e_srst));
    check("ready", 32'(TX_READY),   32'(m_ph == PH_READY));
    check("fail",  32'(TX_FAIL),    32'(m_ph == PH_FAIL));
    check("retry", 32'(RETRY_CNT),  32'(m_retry));
  endtask

  // ---------------- stimulus helpers (all start and end at negedge) -------
  task automatic step(input logic pll, input logic trd, input logic sd);
    check_outputs();
    PLLLKDET    = pll;
    TXRESETDONE = trd;
    SYNC_DONE   = sd;
    @(posedge CLK);
    model_step(pll, trd, sd);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Reset asserted between clock edges; outputs must follow immediately.
  task automatic async_reset();
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Lock held high (except an optional one-cycle glitch at step glitch_at);
  // TXRESETDONE trd_dly edges after GTX falls, SYNC_DONE sd_dly edges after
  // SYNC_RST falls. Returns the edge numbers at which GTX fell / READY rose.
  task automatic run_seq(input int glitch_at, input int trd_dly, input int sd_dly,
                         input int max_steps, output int fall_edge, output int ready_edge);
    int  srst_fall;
    logic trd, sd;
    fall_edge  = -1;
    ready_edge = -1;
    srst_fall  = -1;
    for (int e = 0; e < max_steps && ready_edge < 0; e++) begin
      trd = (fall_edge >= 0) && (e - fall_edge >= trd_dly);
      sd  = (srst_fall >= 0) && (e - srst_fall >= sd_dly);
      step(e != glitch_at, trd, sd);
      if (fall_edge < 0 && GTXTXRESET === 1'b0) fall_edge = e + 1;
      if (srst_fall < 0 && SYNC_RST === 1'b0) srst_fall = e + 1;
      if (TX_READY === 1'b1) ready_edge = e + 1;
    end
  endtask

  task automatic directed_tests();
    int f, r;
    // Test 1: clean bring-up.
    do_reset();
    run_seq(-1, 3, 10, 80, f, r);
    check("t1_gtx_fall_edge", f, 13);
    check("t1_ready_edge", r, 28);
    check("t1_retry", 32'(RETRY_CNT), 0);

    // Test 2: one-cycle lock glitch when lcnt has reached 5.
    do_reset();
    run_seq(6, 3, 10, 80, f, r);
    check("t2_gtx_fall_edge", f, 19);
    check("t2_ready_edge", r, 34);

    // Test 3: lock loss while Ready.
    step(1'b0, 1'b0, 1'b0);
    check("t3_ready_drop", 32'(TX_READY), 0);
    check("t3_gtx_rise", 32'(GTXTXRESET), 1);
    run_seq(-1, 3, 10, 80, f, r);
    check("t3_gtx_fall_edge", f, 12);
    check("t3_ready_edge", r, 27);
    check("t3_retry", 32'(RETRY_CNT), 0);

    // Test 6: reset pulsed during Sync, then a clean restart.
    do_reset();
    run_seq(-1, 3, 1000, 25, f, r);
    check("t6_in_sync", 32'(SYNC_RST), 0);
    async_reset();
    check("t6_arst_gtx", 32'(GTXTXRESET), 1);
    check("t6_arst_srst", 32'(SYNC_RST), 1);
    run_seq(-1, 3, 10, 80, f, r);
    check("t6_gtx_fall_edge", f, 13);
    check("t6_ready_edge", r, 28);
  endtask

`ifdef TXRST_WATCHDOG_EN
  task automatic watchdog_tests();
    int   low, nwin;
    logic was_low, done;
    // Test 4: SYNC_DONE never arrives.
    do_reset();
    low  = 0;
    nwin = 0;
    for (int i = 0; i < 400; i++) begin
      was_low = (SYNC_RST === 1'b0);
      step(1'b1, 1'b1, 1'b0);
      if (SYNC_RST === 1'b0) begin
        low++;
      end else if (was_low) begin
        check($sformatf("t4_window%0d", nwin), low, ST);
        nwin++;
        low = 0;
        if (nwin <= MR) begin
          check($sformatf("t4_retry%0d", nwin), 32'(RETRY_CNT), nwin);
        end else begin
          check("t4_fail", 32'(TX_FAIL), 1);
          check("t4_fail_gtx", 32'(GTXTXRESET), 1);
        end
      end
    end
    check("t4_windows", nwin, MR + 1);
    check("t4_fail_held", 32'(TX_FAIL), 1);
    check("t4_retry_final", 32'(RETRY_CNT), MR);

    // Test 5: SYNC_DONE exactly on the timeout cycle.
    do_reset();
    low  = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step(1'b1, 1'b1, low == ST);
      if (SYNC_RST === 1'b0) low++;
      if (TX_READY === 1'b1) done = 1'b1;
    end
    check("t5_ready", 32'(TX_READY), 1);
    check("t5_window", low, ST + 1);
    check("t5_retry", 32'(RETRY_CNT), 0);
  endtask
`endif

  task automatic random_tests();
    logic pll, trd, sd;
    int   sd_mode;
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      sd_mode = seg % 3;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 799) == 0) async_reset();
        pll = ($urandom_range(0, 299) != 0);
        trd = ($urandom_range(0, 3) == 0);
        case (sd_mode)
          0:       sd = ($urandom_range(0, 20) == 0);
          1:       sd = ($urandom_range(0, 200) == 0);
          default: sd = 1'b0;
        endcase
        if (WdEn && m_ph == PH_SYNC && m_cnt == ST - 1 && $urandom_range(0, 1) == 1) sd = 1'b1;
        step(pll, trd, sd);
      end
    end
  endtask

  initial begin
    @(negedge CLK);
    directed_tests();
`ifdef TXRST_WATCHDOG_EN
    watchdog_tests();
`endif
    random_tests();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: got no completion, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
